// File: rtl/hci_outstanding_arbiter.sv
// hci_outstanding_arbiter: round-robin share of one HCI-Outstanding target port among N_INIT initiators.
// Latency: request and response paths are both combinational (zero cycles). A route FIFO returns in-order responses.
// Backpressure: grants stop when the route FIFO is full (registered count). Target response ready follows the ready of the head initiator.
// Optional macro HCI_OUTSTANDING_ARB_PERF_EN adds grant and stall performance counters.
module hci_outstanding_arbiter #(
  parameter int unsigned N_INIT    = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 64,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      enable_i,
  input  logic [N_INIT-1:0]         init_req_valid_i,
  output logic [N_INIT-1:0]         init_req_ready_o,
  input  logic [N_INIT*AW-1:0]      init_req_add_i,
  input  logic [N_INIT-1:0]         init_req_wen_i,
  input  logic [N_INIT*DW/8-1:0]    init_req_be_i,
  input  logic [N_INIT*DW-1:0]      init_req_data_i,
  output logic [N_INIT-1:0]         init_resp_valid_o,
  input  logic [N_INIT-1:0]         init_resp_ready_i,
  output logic [DW-1:0]             init_resp_data_o,
  output logic                      tgt_req_valid_o,
  input  logic                      tgt_req_ready_i,
  output logic [AW-1:0]             tgt_req_add_o,
  output logic                      tgt_req_wen_o,
  output logic [DW/8-1:0]           tgt_req_be_o,
  output logic [DW-1:0]             tgt_req_data_o,
  input  logic                      tgt_resp_valid_i,
  output logic                      tgt_resp_ready_o,
  input  logic [DW-1:0]             tgt_resp_data_i,
  output logic [$clog2(MAX_OUTST):0] outst_cnt_o,
  output logic                      err_o
`ifdef HCI_OUTSTANDING_ARB_PERF_EN
  ,
  output logic [31:0]               perf_gnt_cnt_o,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  localparam int unsigned IW  = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int unsigned FAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTST) + 1;
  localparam int unsigned BW  = DW / 8;
  localparam logic [IW:0] N_L = (IW+1)'(N_INIT);

  // Arbitration state: round-robin pointer and the offered-but-unaccepted winner.
  logic [IW-1:0]  ptr_q, ptr_d;
  logic           lock_q, lock_d;
  logic [IW-1:0]  lock_idx_q, lock_idx_d;

  // Route FIFO: winner index of every accepted request, popped by responses.
  logic [IW-1:0]  route_q [MAX_OUTST];
  logic [FAW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           full, empty, arb_en;
  logic           win_found;
  logic [IW-1:0]  win_idx;
  logic [IW:0]    sum;
  logic [IW-1:0]  head;
  logic           push, pop;

  assign full   = (cnt_q == CW'(MAX_OUTST));
  assign empty  = (cnt_q == '0);
  assign arb_en = enable_i & ~full & ~rst_i;
  assign head   = route_q[rd_q];

  // Winner selection: a held winner keeps priority, otherwise first requester at or after ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    if (lock_q && init_req_valid_i[lock_idx_q]) begin
      win_found = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < N_INIT; k++) begin
        sum = {1'b0, ptr_q} + (IW+1)'(k);
        if (sum >= N_L) sum = sum - N_L;
        if (!win_found && init_req_valid_i[sum[IW-1:0]]) begin
          win_found = 1'b1;
          win_idx   = sum[IW-1:0];
        end
      end
    end
  end

  assign tgt_req_valid_o = arb_en & win_found;
  assign push            = tgt_req_valid_o & tgt_req_ready_i;

  // Forward the winner's fields to the target and its grant back; all zero when idle.
  always_comb begin
    tgt_req_add_o    = '0;
    tgt_req_wen_o    = 1'b0;
    tgt_req_be_o     = '0;
    tgt_req_data_o   = '0;
    init_req_ready_o = '0;
    for (int i = 0; i < N_INIT; i++) begin
      if (tgt_req_valid_o && (win_idx == IW'(i))) begin
        tgt_req_add_o       = init_req_add_i[i*AW +: AW];
        tgt_req_wen_o       = init_req_wen_i[i];
        tgt_req_be_o        = init_req_be_i[i*BW +: BW];
        tgt_req_data_o      = init_req_data_i[i*DW +: DW];
        init_req_ready_o[i] = tgt_req_ready_i;
      end
    end
  end

  // Steer the target response to the FIFO head; an empty FIFO swallows stray responses.
  always_comb begin
    init_resp_valid_o = '0;
    tgt_resp_ready_o  = 1'b1;
    if (!rst_i && !empty) begin
      tgt_resp_ready_o = init_resp_ready_i[head];
      for (int i = 0; i < N_INIT; i++) begin
        if (head == IW'(i)) init_resp_valid_o[i] = tgt_resp_valid_i;
      end
    end
  end

  assign init_resp_data_o = tgt_resp_data_i;
  assign pop              = tgt_resp_valid_i & ~empty & tgt_resp_ready_o;

  // Next-state for pointer, lock, FIFO pointers, occupancy and sticky error.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = tgt_req_valid_o & ~tgt_req_ready_i;
    lock_idx_d = win_idx;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (tgt_resp_valid_i & empty);
    if (push) begin
      ptr_d = (win_idx == IW'(N_INIT-1)) ? '0 : win_idx + IW'(1);
      wr_d  = wr_q + FAW'(1);
    end
    if (pop) rd_d = rd_q + FAW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; reset dominates clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Route FIFO storage; contents are meaningless outside the rd..wr window.
  always_ff @(posedge clk_i) begin
    if (push) route_q[wr_q] <= win_idx;
  end

  assign outst_cnt_o = cnt_q;
  assign err_o       = err_q;

`ifdef HCI_OUTSTANDING_ARB_PERF_EN
  logic [31:0] perf_gnt_q, perf_stall_q;

  // Saturating counters of grants and of cycles where a request waited without a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      perf_gnt_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push && (perf_gnt_q != 32'hFFFF_FFFF)) perf_gnt_q <= perf_gnt_q + 32'd1;
      if ((|init_req_valid_i) && !push && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_gnt_cnt_o   = perf_gnt_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hci_outstanding_arbiter.sv
// Bench for hci_outstanding_arbiter: directed scenarios with literal expectations,
// then randomized traffic; every cycle is compared against a queue-based model.
module tb_hci_outstanding_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MO = 8;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clear, enable;
  logic [N-1:0]      init_req_valid, init_req_ready, init_req_wen;
  logic [N*AW-1:0]   init_req_add;
  logic [N*BW-1:0]   init_req_be;
  logic [N*DW-1:0]   init_req_data;
  logic [N-1:0]      init_resp_valid, init_resp_ready;
  logic [DW-1:0]     init_resp_data;
  logic              tgt_req_valid, tgt_req_ready, tgt_req_wen;
  logic [AW-1:0]     tgt_req_add;
  logic [BW-1:0]     tgt_req_be;
  logic [DW-1:0]     tgt_req_data;
  logic              tgt_resp_valid, tgt_resp_ready;
  logic [DW-1:0]     tgt_resp_data;
  logic [3:0]        outst_cnt;
  logic              err;
`ifdef HCI_OUTSTANDING_ARB_PERF_EN
  logic [31:0]       perf_gnt, perf_stall;
`endif

  hci_outstanding_arbiter #(.N_INIT(N), .AW(AW), .DW(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
    .init_req_valid_i(init_req_valid), .init_req_ready_o(init_req_ready),
    .init_req_add_i(init_req_add), .init_req_wen_i(init_req_wen),
    .init_req_be_i(init_req_be), .init_req_data_i(init_req_data),
    .init_resp_valid_o(init_resp_valid), .init_resp_ready_i(init_resp_ready),
    .init_resp_data_o(init_resp_data),
    .tgt_req_valid_o(tgt_req_valid), .tgt_req_ready_i(tgt_req_ready),
    .tgt_req_add_o(tgt_req_add), .tgt_req_wen_o(tgt_req_wen),
    .tgt_req_be_o(tgt_req_be), .tgt_req_data_o(tgt_req_data),
    .tgt_resp_valid_i(tgt_resp_valid), .tgt_resp_ready_o(tgt_resp_ready),
    .tgt_resp_data_i(tgt_resp_data),
    .outst_cnt_o(outst_cnt), .err_o(err)
`ifdef HCI_OUTSTANDING_ARB_PERF_EN
    , .perf_gnt_cnt_o(perf_gnt), .perf_stall_cnt_o(perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of in-flight initiator indices plus arbitration bookkeeping.
  int          q[$];
  int          ptr;
  int          held;
  bit          err_m;
  logic [31:0] m_gnt, m_stall;
  bit          e_push, e_pop, e_stray;
  int          e_win, e_held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ptr = 0; held = -1; err_m = 0; m_gnt = '0; m_stall = '0;
  endtask

  // Compare every DUT output against what the model says it must be right now.
  task automatic compare();
    bit found, arb, e_tv, e_rr;
    int win, h;
    logic [N-1:0]  e_rdy, e_rv;
    logic [AW-1:0] e_add;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_dat;
    logic          e_wen;
    arb = enable && (q.size() < MO) && !rst;
    found = 0; win = 0;
    if (held >= 0 && init_req_valid[held]) begin
      found = 1; win = held;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (!found && init_req_valid[c]) begin found = 1; win = c; end
      end
    end
    e_tv  = arb && found;
    e_add = e_tv ? init_req_add[win*AW +: AW] : '0;
    e_be  = e_tv ? init_req_be[win*BW +: BW] : '0;
    e_dat = e_tv ? init_req_data[win*DW +: DW] : '0;
    e_wen = e_tv ? init_req_wen[win] : 1'b0;
    e_rdy = '0;
    if (e_tv && tgt_req_ready) e_rdy[win] = 1'b1;
    e_rv = '0;
    if (rst || q.size() == 0) begin
      e_rr = 1;
    end else begin
      h = q[0];
      e_rr = init_resp_ready[h];
      e_rv[h] = tgt_resp_valid;
    end
    chk("tgt_req_valid", tgt_req_valid, e_tv);
    chk("tgt_req_add", tgt_req_add, e_add);
    chk("tgt_req_be", tgt_req_be, e_be);
    chk("tgt_req_data", tgt_req_data, e_dat);
    chk("tgt_req_wen", tgt_req_wen, e_wen);
    chk("init_req_ready", init_req_ready, e_rdy);
    chk("init_resp_valid", init_resp_valid, e_rv);
    chk("tgt_resp_ready", tgt_resp_ready, e_rr);
    chk("init_resp_data", init_resp_data, tgt_resp_data);
    chk("outst_cnt", outst_cnt, q.size());
    chk("err", err, err_m);
`ifdef HCI_OUTSTANDING_ARB_PERF_EN
    chk("perf_gnt", perf_gnt, m_gnt);
    chk("perf_stall", perf_stall, m_stall);
`endif
    e_push  = e_tv && tgt_req_ready;
    e_win   = win;
    e_pop   = !rst && q.size() > 0 && tgt_resp_valid && e_rr;
    e_stray = tgt_resp_valid && q.size() == 0;
    e_held  = (e_tv && !tgt_req_ready) ? win : -1;
  endtask

  task automatic model_update();
    if (rst || clear) begin
      model_reset();
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
        q.push_back(e_win);
        ptr = (e_win + 1) % N;
      end
      held = e_held;
      if (e_stray) err_m = 1;
      if (e_push && m_gnt != 32'hFFFF_FFFF) m_gnt = m_gnt + 1;
      if ((|init_req_valid) && !e_push && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end
  endtask

  // One cycle: inputs were applied at the falling edge; check, clock, advance model.
  task automatic cyc();
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic fixed_fields();
    for (int i = 0; i < N; i++) begin
      init_req_add[i*AW +: AW]  = 32'h1000_0000 + 32'(i * 16);
      init_req_be[i*BW +: BW]   = 8'(8'h11 << i);
      init_req_data[i*DW +: DW] = 64'hD000_0000_0000_0000 + 64'(i);
      init_req_wen[i]           = i[0];
    end
  endtask

  initial begin
    rst = 1; clear = 0; enable = 0; init_req_valid = '0; tgt_req_ready = 0;
    init_resp_ready = '1; tgt_resp_valid = 0; tgt_resp_data = '0;
    fixed_fields();
    @(negedge clk); @(negedge clk);
    model_reset();

    // Held in reset with every request raised: nothing may be granted.
    init_req_valid = 4'hF; enable = 1; tgt_req_ready = 1;
    #1;
    chk("rst_tgt_req_valid", tgt_req_valid, 0);
    chk("rst_init_req_ready", init_req_ready, 0);
    chk("rst_outst_cnt", outst_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_tgt_resp_ready", tgt_resp_ready, 1);
    cyc();
    rst = 0;

    // Round-robin with everyone requesting, then fill the route FIFO.
    for (int g = 0; g < 4; g++) begin
      #1 chk("rr_grant", init_req_ready, 64'(4'b0001 << g));
      cyc();
    end
    #1 chk("rr_cnt4", outst_cnt, 4);
    repeat (4) cyc();
    #1;
    chk("full_cnt", outst_cnt, 8);
    chk("full_tgt_req_valid", tgt_req_valid, 0);
    chk("full_init_req_ready", init_req_ready, 0);

    // One response while full: routed to head (initiator 0), grant resumes next cycle.
    tgt_resp_valid = 1; tgt_resp_data = 64'hA;
    #1;
    chk("full_resp_route", init_resp_valid, 4'b0001);
    chk("full_no_push_same_cycle", tgt_req_valid, 0);
    cyc();
    tgt_resp_valid = 0;
    #1 chk("resume_grant", init_req_ready, 4'b0001);
    cyc();

    // Clear, then a stray response sets the sticky error until the next clear.
    init_req_valid = '0; clear = 1; cyc(); clear = 0;
    #1 chk("clear_cnt", outst_cnt, 0);
    tgt_resp_valid = 1;
    #1;
    chk("stray_ready", tgt_resp_ready, 1);
    chk("stray_no_valid", init_resp_valid, 0);
    cyc();
    tgt_resp_valid = 0;
    #1 chk("stray_err_set", err, 1);
    cyc();
    #1 chk("stray_err_sticky", err, 1);
    clear = 1; cyc(); clear = 0;
    #1 chk("clear_err", err, 0);

    // Held request: initiator 2 alone under a stalled target, then 0 joins.
    init_req_valid = 4'b0100; tgt_req_ready = 0;
    repeat (3) begin
      #1 chk("held_add", tgt_req_add, 32'h1000_0020);
      cyc();
    end
    init_req_valid = 4'b0101;
    #1 chk("held_add_after_0", tgt_req_add, 32'h1000_0020);
    cyc();
    tgt_req_ready = 1;
    #1 chk("held_grant", init_req_ready, 4'b0100);
    cyc();

    // Routing of responses back to 1, 3, 1 with a stalled initiator 3.
    init_req_valid = '0; clear = 1; cyc(); clear = 0;
    init_req_valid = 4'b0010; cyc();
    init_req_valid = 4'b1000; cyc();
    init_req_valid = 4'b0010; cyc();
    init_req_valid = '0;
    tgt_resp_valid = 1; tgt_resp_data = 64'hA; init_resp_ready = 4'hF;
    #1 chk("route_first", init_resp_valid, 4'b0010);
    cyc();
    tgt_resp_data = 64'hB; init_resp_ready = 4'b0111;
    #1;
    chk("route_second", init_resp_valid, 4'b1000);
    chk("route_stall", tgt_resp_ready, 0);
    cyc();
    init_resp_ready = 4'hF;
    #1 chk("route_unstall", tgt_resp_ready, 1);
    cyc();
    tgt_resp_data = 64'hC;
    #1;
    chk("route_third", init_resp_valid, 4'b0010);
    chk("route_data", init_resp_data, 64'hC);
    cyc();
    tgt_resp_valid = 0;
    #1 chk("route_drained", outst_cnt, 0);

    // Reset mid-burst: occupancy clears and the pointer restarts at 0.
    init_req_valid = 4'hF;
    repeat (3) cyc();
    rst = 1; cyc(); rst = 0;
    #1;
    chk("midrst_cnt", outst_cnt, 0);
    chk("midrst_ptr", init_req_ready, 4'b0001);
    cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst             = ($urandom_range(0, 299) == 0);
      clear           = ($urandom_range(0, 199) == 0);
      enable          = ($urandom_range(0, 9) != 0);
      init_req_valid  = N'($urandom);
      tgt_req_ready   = ($urandom_range(0, 3) != 0);
      tgt_resp_valid  = ($urandom_range(0, 1) != 0);
      tgt_resp_data   = {$urandom, $urandom};
      init_resp_ready = N'($urandom | $urandom);
      for (int i = 0; i < N; i++) begin
        init_req_add[i*AW +: AW]  = $urandom;
        init_req_be[i*BW +: BW]   = BW'($urandom);
        init_req_data[i*DW +: DW] = {$urandom, $urandom};
        init_req_wen[i]           = 1'($urandom);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
